// File: rtl/game_pkg.sv
// Purpose : shared screen geometry and ball state encoding for the brick-smash game.
// Latency : n/a (constants and types only).
// Backpressure: none.
package game_pkg;

  localparam int H_DISPLAY = 256;  // visible width, matches the sync generator
  localparam int V_DISPLAY = 240;  // visible height, matches the sync generator
  localparam int BALL_SIZE = 4;    // square ball edge length

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    MISS = 2'd2
  } state_t;

endpackage

// File: rtl/ball_axis.sv
// Purpose : position/direction register for one ball axis with wall clamps.
// Latency : position updates on the edge where i_step or i_load is high.
// Backpressure: none; i_step is a single-cycle strobe.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   i_load     : reload START position and START_NEG direction
//   i_step     : apply one step (after flip) this edge
//   i_flip     : invert direction before stepping
//   o_pos      : current position (low edge of the ball)
//   o_over     : a step now would cross the high limit on an unclamped axis
module ball_axis #(
  parameter int SPEED      = 1,
  parameter int START      = 128,
  parameter bit START_NEG  = 1'b0,
  parameter int LIMIT      = 252,
  parameter bit HIGH_CLAMP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_step,
  input  logic       i_flip,
  output logic [8:0] o_pos,
  output logic       o_over
);

  localparam logic [8:0] SPEED9  = 9'(SPEED);
  localparam logic [8:0] START9  = 9'(START);
  localparam logic [8:0] LIMIT9  = 9'(LIMIT);
  localparam logic [9:0] LIMIT10 = 10'(LIMIT);

  logic [8:0] r_pos;
  logic       r_neg;

  logic       w_neg;
  logic [9:0] w_sum;
  logic [8:0] w_diff;
  logic       w_low;
  logic       w_high;

  // Direction after any pending reflection; step and clamps both use it.
  assign w_neg  = r_neg ^ i_flip;
  // 10-bit sum so a step near 511 cannot wrap past the limit compare.
  assign w_sum  = {1'b0, r_pos} + {1'b0, SPEED9};
  assign w_diff = r_pos - SPEED9;
  assign w_low  = (r_pos < SPEED9);
  assign w_high = (w_sum > LIMIT10);

  // Only an axis without a high wall reports leaving the play field.
  assign o_over = !HIGH_CLAMP && !w_neg && w_high;
  assign o_pos  = r_pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos <= START9;
      r_neg <= START_NEG;
    end else if (i_load) begin
      r_pos <= START9;
      r_neg <= START_NEG;
    end else if (i_step) begin
      if (w_neg) begin
        if (w_low) begin
          r_pos <= 9'd0;
          r_neg <= 1'b0;
        end else begin
          r_pos <= w_diff;
          r_neg <= 1'b1;
        end
      end else if (HIGH_CLAMP && w_high) begin
        r_pos <= LIMIT9;
        r_neg <= 1'b1;
      end else begin
        r_pos <= w_sum[8:0];
        r_neg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Purpose : ball object; per-frame motion, wall/collision reflection, miss detect, pixel graphic.
// Latency : motion applied on the tick edge (frame_tick same edge); ball_gfx 1 cycle after hpos/vpos.
// Backpressure: none; collide/serve requests are latched until the next frame tick.
//
// Ports:
//   clk, reset          : pixel clock, synchronous active-high reset
//   hpos, vpos          : beam counters from the sync generator
//   serve               : launch request, honoured in IDLE at the next tick
//   collide_h/collide_v : reflect requests from brick/paddle logic
//   ball_gfx            : beam pixel is inside the ball (registered)
//   ball_x, ball_y      : ball left/top edge
//   ball_active         : ball is in play
//   frame_tick, miss    : one-cycle pulses for the frame update and a bottom exit
module ball_motion
  import game_pkg::*;
#(
  parameter int SPEED   = 1,
  parameter int START_X = 128,
  parameter int START_Y = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       serve,
  input  logic       collide_h,
  input  logic       collide_v,
  output logic       ball_gfx,
  output logic [8:0] ball_x,
  output logic [8:0] ball_y,
  output logic       ball_active,
  output logic       frame_tick,
  output logic       miss
);

  state_t r_state;
  logic   r_lat_h;
  logic   r_lat_v;
  logic   r_serve_pend;
  logic   r_frame_tick;
  logic   r_miss;
  logic   r_gfx;

  logic       w_tick;
  logic       w_exit;
  logic       w_load;
  logic       w_step;
  logic       w_x_over;
  logic       w_y_over;
  logic [8:0] w_x;
  logic [8:0] w_y;
  logic       w_hit;

  // First blanking line, first pixel.
  assign w_tick = (hpos == 9'd0) && (vpos == 9'(V_DISPLAY));
  assign w_exit = w_x_over | w_y_over;
  // Outside PLAY every tick re-seats the serve position and direction.
  assign w_load = (r_state != PLAY) && w_tick;
  // The tick that detects the exit freezes position for the miss frame.
  assign w_step = (r_state == PLAY) && w_tick && !w_exit;

  ball_axis #(
    .SPEED      (SPEED),
    .START      (START_X),
    .START_NEG  (1'b0),
    .LIMIT      (H_DISPLAY - BALL_SIZE),
    .HIGH_CLAMP (1'b1)
  ) u_axis_x (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_flip (r_lat_h),
    .o_pos  (w_x),
    .o_over (w_x_over)
  );

  ball_axis #(
    .SPEED      (SPEED),
    .START      (START_Y),
    .START_NEG  (1'b1),
    .LIMIT      (V_DISPLAY - BALL_SIZE),
    .HIGH_CLAMP (1'b0)
  ) u_axis_y (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_flip (r_lat_v),
    .o_pos  (w_y),
    .o_over (w_y_over)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lat_h      <= 1'b0;
      r_lat_v      <= 1'b0;
      r_serve_pend <= 1'b0;
      r_frame_tick <= 1'b0;
      r_miss       <= 1'b0;
    end else begin
      r_frame_tick <= w_tick;
      r_miss       <= 1'b0;

      // A request in the tick cycle itself survives the clear (set wins).
      if (r_state != PLAY) begin
        r_lat_h <= 1'b0;
        r_lat_v <= 1'b0;
      end else begin
        r_lat_h <= collide_h | (r_lat_h & ~w_tick);
        r_lat_v <= collide_v | (r_lat_v & ~w_tick);
      end

      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_serve_pend <= 1'b0;
            if (serve || r_serve_pend) begin
              r_state <= PLAY;
            end
          end else if (serve) begin
            r_serve_pend <= 1'b1;
          end
        end
        PLAY: begin
          if (w_tick && w_exit) begin
            r_state <= MISS;
            r_miss  <= 1'b1;
          end
        end
        MISS: begin
          if (w_tick) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // 10-bit compares so ball_x + BALL_SIZE near 511 does not wrap.
  assign w_hit = ({1'b0, hpos} >= {1'b0, w_x}) &&
                 ({1'b0, hpos} <  ({1'b0, w_x} + 10'(BALL_SIZE))) &&
                 ({1'b0, vpos} >= {1'b0, w_y}) &&
                 ({1'b0, vpos} <  ({1'b0, w_y} + 10'(BALL_SIZE)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gfx <= 1'b0;
    end else begin
      r_gfx <= (r_state != MISS) && w_hit;
    end
  end

  assign ball_gfx    = r_gfx;
  assign ball_x      = w_x;
  assign ball_y      = w_y;
  assign ball_active = (r_state == PLAY);
  assign frame_tick  = r_frame_tick;
  assign miss        = r_miss;

endmodule

// File: tb/tb_ball_motion.sv
// Purpose : directed self-checking bench for ball_motion (default and SPEED=2 instances).
// Latency : every check samples 1 time unit after the edge that consumed the inputs.
// Backpressure: n/a.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos;
  logic [8:0] vpos;

  logic       serve_a, collide_h_a, collide_v_a;
  logic       gfx_a, active_a, tick_a, miss_a;
  logic [8:0] x_a, y_a;

  logic       serve_b, collide_h_b, collide_v_b;
  logic       gfx_b, active_b, tick_b, miss_b;
  logic [8:0] x_b, y_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ball_motion u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .serve       (serve_a),
    .collide_h   (collide_h_a),
    .collide_v   (collide_v_a),
    .ball_gfx    (gfx_a),
    .ball_x      (x_a),
    .ball_y      (y_a),
    .ball_active (active_a),
    .frame_tick  (tick_a),
    .miss        (miss_a)
  );

  ball_motion #(
    .SPEED   (2),
    .START_X (251),
    .START_Y (100)
  ) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .serve       (serve_b),
    .collide_h   (collide_h_b),
    .collide_v   (collide_v_b),
    .ball_gfx    (gfx_b),
    .ball_x      (x_b),
    .ball_y      (y_b),
    .ball_active (active_b),
    .frame_tick  (tick_b),
    .miss        (miss_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock with the beam at (h, v); returns 1 time unit after the edge.
  task automatic cyc(input int h, input int v);
    @(negedge clk);
    hpos = 9'(h);
    vpos = 9'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    cyc(0, 240);
  endtask

  initial begin
    reset = 1'b1;
    hpos = '0; vpos = '0;
    serve_a = 0; collide_h_a = 0; collide_v_a = 0;
    serve_b = 0; collide_h_b = 0; collide_v_b = 0;
    cyc(0, 0);
    cyc(0, 0);
    check("rst_x", x_a, 128);
    check("rst_y", y_a, 128);
    check("rst_active", active_a, 0);
    check("rst_gfx", gfx_a, 0);
    check("rst_tick", tick_a, 0);
    check("rst_miss", miss_a, 0);
    reset = 1'b0;

    // Idle for three frames: ball parked and drawn.
    for (int i = 0; i < 3; i++) begin
      cyc(7, 7);
      tick();
      check("idle_ftick", tick_a, 1);
    end
    cyc(7, 7);
    check("idle_ftick_low", tick_a, 0);
    check("idle_x", x_a, 128);
    check("idle_y", y_a, 128);
    check("idle_active", active_a, 0);
    for (int v = 126; v <= 133; v++) begin
      for (int h = 126; h <= 133; h++) begin
        cyc(h, v);
        check("idle_gfx", gfx_a,
              (h >= 128 && h <= 131 && v >= 128 && v <= 131) ? 1 : 0);
      end
    end

    // SPEED=2 instance: right wall clamp, top clamp, left wall clamp.
    serve_b = 1;
    cyc(0, 10);
    serve_b = 0;
    check("b_serve_wait", active_b, 0);
    tick();
    check("b_serve_active", active_b, 1);
    check("b_serve_x", x_b, 251);
    tick();
    check("b_n1_x", x_b, 252);
    check("b_n1_y", y_b, 98);
    tick();
    check("b_n2_x", x_b, 250);
    check("b_n2_y", y_b, 96);
    for (int n = 3; n <= 51; n++) tick();
    check("b_n51_y", y_b, 0);
    check("b_n51_x", x_b, 152);
    tick();
    check("b_n52_y", y_b, 2);
    check("b_n52_x", x_b, 150);
    for (int n = 53; n <= 127; n++) tick();
    check("b_n127_x", x_b, 0);
    tick();
    check("b_n128_x", x_b, 0);
    tick();
    check("b_n129_x", x_b, 2);
    check("b_n129_y", y_b, 156);
    check("a_still_idle_x", x_a, 128);
    check("a_still_idle_act", active_a, 0);

    // Serve the default instance mid-frame; it launches on the next tick.
    serve_a = 1;
    cyc(0, 10);
    serve_a = 0;
    cyc(9, 11);
    check("a_serve_wait", active_a, 0);
    tick();
    check("a_serve_active", active_a, 1);
    check("a_serve_x", x_a, 128);
    check("a_serve_y", y_a, 128);
    for (int i = 0; i < 5; i++) tick();
    check("a_5_x", x_a, 133);
    check("a_5_y", y_a, 123);
    for (int i = 0; i < 23; i++) tick();
    check("a_28_x", x_a, 156);
    check("a_28_y", y_a, 100);

    // Vertical reflect from a mid-frame collision.
    collide_v_a = 1;
    cyc(0, 50);
    collide_v_a = 0;
    tick();
    check("cv_y", y_a, 101);
    check("cv_x", x_a, 157);
    // Collision coincident with the tick applies one frame later.
    collide_v_a = 1;
    tick();
    collide_v_a = 0;
    check("cv_tick_y", y_a, 102);
    tick();
    check("cv_late_y", y_a, 101);
    check("cv_late_x", x_a, 159);
    // Both axes reflect together.
    collide_h_a = 1;
    collide_v_a = 1;
    cyc(3, 20);
    collide_h_a = 0;
    collide_v_a = 0;
    tick();
    check("chv_x", x_a, 158);
    check("chv_y", y_a, 102);

    // Fall to the bottom edge and exit.
    for (int i = 0; i < 134; i++) tick();
    check("bot_x", x_a, 24);
    check("bot_y", y_a, 236);
    check("bot_active", active_a, 1);
    tick();
    check("miss_pulse", miss_a, 1);
    check("miss_ftick", tick_a, 1);
    check("miss_active", active_a, 0);
    check("miss_x_hold", x_a, 24);
    check("miss_y_hold", y_a, 236);
    cyc(24, 236);
    check("miss_pulse_end", miss_a, 0);
    check("miss_gfx0", gfx_a, 0);
    cyc(25, 237);
    check("miss_gfx1", gfx_a, 0);
    tick();
    check("reload_x", x_a, 128);
    check("reload_y", y_a, 128);
    check("reload_active", active_a, 0);
    cyc(128, 128);
    check("reload_gfx", gfx_a, 1);

    // Reset in the middle of play with a pending collision latch.
    serve_a = 1;
    cyc(0, 10);
    serve_a = 0;
    tick();
    tick();
    check("pre_rst_x", x_a, 129);
    check("pre_rst_y", y_a, 127);
    collide_h_a = 1;
    cyc(5, 5);
    collide_h_a = 0;
    reset = 1'b1;
    cyc(100, 60);
    check("mrst_x", x_a, 128);
    check("mrst_y", y_a, 127 + 1);
    check("mrst_active", active_a, 0);
    check("mrst_ftick", tick_a, 0);
    check("mrst_miss", miss_a, 0);
    check("mrst_gfx", gfx_a, 0);
    check("mrst_b_x", x_b, 251);
    cyc(0, 240);
    check("mrst_tick_suppressed", tick_a, 0);
    reset = 1'b0;
    serve_a = 1;
    cyc(0, 10);
    serve_a = 0;
    tick();
    tick();
    check("post_rst_x", x_a, 129);
    check("post_rst_y", y_a, 127);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
